eater_datapath: RTL and testbench

//   Downstream consumer of the 16-bit control word from the microcode sequencer. Holds the
//   8-bit bus, A/B registers, ALU, flags, PC, MAR, 16x8 RAM, IR and output register, and

---
 rtl/eater_pkg.sv | 36 +++
 rtl/eater_datapath_if.sv | 36 +++
 rtl/eater_alu.sv | 26 ++
 rtl/eater_datapath.sv | 116 +++++++++++
 tb/tb_eater_datapath.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/eater_pkg.sv
// Shared constants for the SAP-1 style datapath and its microcode sequencer:
// control-word bit positions and instruction opcodes.
package eater_pkg;

  localparam int CTRL_W = 16;

  localparam int CTRL_HLT = 15;
  localparam int CTRL_MI  = 14;
  localparam int CTRL_RI  = 13;
  localparam int CTRL_RO  = 12;
  localparam int CTRL_IO  = 11;
  localparam int CTRL_II  = 10;
  localparam int CTRL_AI  = 9;
  localparam int CTRL_AO  = 8;
  localparam int CTRL_EO  = 7;
  localparam int CTRL_SU  = 6;
  localparam int CTRL_BI  = 5;
  localparam int CTRL_OI  = 4;
  localparam int CTRL_CE  = 3;
  localparam int CTRL_CO  = 2;
  localparam int CTRL_J   = 1;
  localparam int CTRL_FI  = 0;

  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] LDA = 4'h1;
  localparam logic [3:0] ADD = 4'h2;
  localparam logic [3:0] SUB = 4'h3;
  localparam logic [3:0] STA = 4'h4;
  localparam logic [3:0] LDI = 4'h5;
  localparam logic [3:0] JMP = 4'h6;
  localparam logic [3:0] JC  = 4'h7;
  localparam logic [3:0] JZ  = 4'h8;
  localparam logic [3:0] OUT = 4'he;
  localparam logic [3:0] HLT = 4'hf;

endpackage

// File: rtl/eater_datapath_if.sv
// Bundle between the microcode sequencer / program loader (master) and the
// datapath (slave): control word and program-load port in, status out.
interface eater_datapath_if
  import eater_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
);

  logic [CTRL_W-1:0] ctrl_word;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [DW-1:0]     prog_data;
  logic [3:0]        instruction;
  logic              flag_c;
  logic              flag_z;
  logic [DW-1:0]     bus_value;
  logic [AW-1:0]     pc;
  logic [DW-1:0]     out_value;
  logic              out_valid;
  logic              halted;
  logic              bus_conflict;

  modport master (
    output ctrl_word, prog_we, prog_addr, prog_data,
    input  instruction, flag_c, flag_z, bus_value, pc,
           out_value, out_valid, halted, bus_conflict
  );

  modport slave (
    input  ctrl_word, prog_we, prog_addr, prog_data,
    output instruction, flag_c, flag_z, bus_value, pc,
           out_value, out_valid, halted, bus_conflict
  );

endinterface

// File: rtl/eater_alu.sv
// Combinational adder/subtractor. Subtraction is A + two's complement of B,
// so carry-out set on a subtract means "no borrow".
module eater_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          su,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] operand;
  logic [DW:0] sum;

  // Form the second operand at full carry width so ~B+1 of B=0 carries out
  always_comb begin
    operand = su ? ({1'b0, ~b} + {{DW{1'b0}}, 1'b1}) : {1'b0, b};
    sum     = {1'b0, a} + operand;
    result  = sum[DW-1:0];
    carry   = sum[DW];
    zero    = (sum[DW-1:0] == '0);
  end

endmodule

// File: rtl/eater_datapath.sv
// SAP-1 datapath: shared bus, A/B registers, ALU with flags, PC, MAR, RAM,
// IR and output register. Executes one control word per clock edge.
module eater_datapath
  import eater_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic clk,
  input  logic rst,
  eater_datapath_if.slave dp
);

  logic [DW-1:0] a_reg, b_reg, ir_reg, out_reg, bus;
  logic [AW-1:0] mar_reg, pc_reg;
  logic          c_reg, z_reg, valid_reg, halt_reg, conflict_reg;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  logic [DW-1:0] alu_result;
  logic          alu_carry, alu_zero;

  logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, jmp, fi;
  logic [2:0] driver_count;
  logic       exec_en;

  assign hlt = dp.ctrl_word[CTRL_HLT];
  assign mi  = dp.ctrl_word[CTRL_MI];
  assign ri  = dp.ctrl_word[CTRL_RI];
  assign ro  = dp.ctrl_word[CTRL_RO];
  assign io  = dp.ctrl_word[CTRL_IO];
  assign ii  = dp.ctrl_word[CTRL_II];
  assign ai  = dp.ctrl_word[CTRL_AI];
  assign ao  = dp.ctrl_word[CTRL_AO];
  assign eo  = dp.ctrl_word[CTRL_EO];
  assign su  = dp.ctrl_word[CTRL_SU];
  assign bi  = dp.ctrl_word[CTRL_BI];
  assign oi  = dp.ctrl_word[CTRL_OI];
  assign ce  = dp.ctrl_word[CTRL_CE];
  assign co  = dp.ctrl_word[CTRL_CO];
  assign jmp = dp.ctrl_word[CTRL_J];
  assign fi  = dp.ctrl_word[CTRL_FI];

  // Once halted, the control word no longer changes any state
  assign exec_en = ~halt_reg;

  eater_alu #(.DW(DW)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .su     (su),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Bus mux with fixed priority; also count drivers to catch microcode bugs
  always_comb begin
    driver_count = {2'b00, ro} + {2'b00, io} + {2'b00, ao} + {2'b00, eo} + {2'b00, co};
    bus = '0;
    if (ro)      bus = ram[mar_reg];
    else if (io) bus = {{(DW-4){1'b0}}, ir_reg[3:0]};
    else if (ao) bus = a_reg;
    else if (eo) bus = alu_result;
    else if (co) bus = {{(DW-AW){1'b0}}, pc_reg};
  end

  // Register file updates from the pre-edge bus; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      ir_reg       <= '0;
      mar_reg      <= '0;
      pc_reg       <= '0;
      out_reg      <= '0;
      c_reg        <= 1'b0;
      z_reg        <= 1'b0;
      valid_reg    <= 1'b0;
      halt_reg     <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      if (exec_en) begin
        if (mi) mar_reg <= bus[AW-1:0];
        if (ii) ir_reg  <= bus;
        if (ai) a_reg   <= bus;
        if (bi) b_reg   <= bus;
        if (oi) out_reg <= bus;
        if (jmp)     pc_reg <= bus[AW-1:0];
        else if (ce) pc_reg <= pc_reg + 1'b1;
        if (fi) begin
          c_reg <= alu_carry;
          z_reg <= alu_zero;
        end
        if (hlt) halt_reg <= 1'b1;
      end
      valid_reg <= exec_en & oi;
      if (driver_count > 3'd1) conflict_reg <= 1'b1;
    end
  end

  // RAM writes; the loader port is ordered last so it wins an address clash
  always_ff @(posedge clk) begin
    if (ri && exec_en && !rst) ram[mar_reg] <= bus;
    if (dp.prog_we) ram[dp.prog_addr] <= dp.prog_data;
  end

  assign dp.instruction  = ir_reg[7:4];
  assign dp.flag_c       = c_reg;
  assign dp.flag_z       = z_reg;
  assign dp.bus_value    = bus;
  assign dp.pc           = pc_reg;
  assign dp.out_value    = out_reg;
  assign dp.out_valid    = valid_reg;
  assign dp.halted       = halt_reg;
  assign dp.bus_conflict = conflict_reg;

endmodule

// File: tb/tb_eater_datapath.sv
// Directed bench for eater_datapath: reset state, a four-instruction program,
// ALU/flag corners, PC wrap and jump priority, bus conflict, halt behaviour.
module tb_eater_datapath;

  localparam logic [15:0] W_HLT = 16'h8000;
  localparam logic [15:0] W_MI  = 16'h4000;
  localparam logic [15:0] W_RO  = 16'h1000;
  localparam logic [15:0] W_IO  = 16'h0800;
  localparam logic [15:0] W_II  = 16'h0400;
  localparam logic [15:0] W_AI  = 16'h0200;
  localparam logic [15:0] W_AO  = 16'h0100;
  localparam logic [15:0] W_EO  = 16'h0080;
  localparam logic [15:0] W_SU  = 16'h0040;
  localparam logic [15:0] W_BI  = 16'h0020;
  localparam logic [15:0] W_OI  = 16'h0010;
  localparam logic [15:0] W_CE  = 16'h0008;
  localparam logic [15:0] W_CO  = 16'h0004;
  localparam logic [15:0] W_J   = 16'h0002;
  localparam logic [15:0] W_FI  = 16'h0001;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  eater_datapath_if #(.DW(8), .AW(4)) dp_if ();

  eater_datapath #(.DW(8), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp_if.slave)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one control word, let one edge happen, settle 1ns past it
  task automatic applyStimulus(input logic [15:0] word);
    dp_if.ctrl_word = word;
    @(posedge clk);
    #1;
  endtask

  task automatic progWrite(input logic [3:0] addr, input logic [7:0] data);
    dp_if.prog_we   = 1'b1;
    dp_if.prog_addr = addr;
    dp_if.prog_data = data;
    applyStimulus(16'h0000);
    dp_if.prog_we   = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    dp_if.ctrl_word = 16'h0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    dp_if.ctrl_word = 16'h0000;
    dp_if.prog_we   = 1'b0;
    dp_if.prog_addr = 4'h0;
    dp_if.prog_data = 8'h00;

    // ---- reset state
    doReset();
    checkOutput("rst_instruction", 16'(dp_if.instruction), 16'h0);
    checkOutput("rst_flag_c", 16'(dp_if.flag_c), 16'h0);
    checkOutput("rst_flag_z", 16'(dp_if.flag_z), 16'h0);
    checkOutput("rst_bus", 16'(dp_if.bus_value), 16'h0);
    checkOutput("rst_pc", 16'(dp_if.pc), 16'h0);
    checkOutput("rst_out_value", 16'(dp_if.out_value), 16'h0);
    checkOutput("rst_out_valid", 16'(dp_if.out_valid), 16'h0);
    checkOutput("rst_halted", 16'(dp_if.halted), 16'h0);
    checkOutput("rst_conflict", 16'(dp_if.bus_conflict), 16'h0);

    // ---- program LDA 14 / ADD 15 / OUT / HLT
    progWrite(4'd0, 8'h1E);
    progWrite(4'd1, 8'h2F);
    progWrite(4'd2, 8'hE0);
    progWrite(4'd3, 8'hF0);
    progWrite(4'd14, 8'd28);
    progWrite(4'd15, 8'd14);

    applyStimulus(W_CO | W_MI);
    applyStimulus(W_RO | W_II | W_CE);
    checkOutput("prog_ir_lda", 16'(dp_if.instruction), 16'h1);
    applyStimulus(W_IO | W_MI);
    applyStimulus(W_RO | W_AI);
    applyStimulus(W_CO | W_MI);
    applyStimulus(W_RO | W_II | W_CE);
    checkOutput("prog_ir_add", 16'(dp_if.instruction), 16'h2);
    applyStimulus(W_IO | W_MI);
    applyStimulus(W_RO | W_BI);
    applyStimulus(W_EO | W_AI | W_FI);
    checkOutput("prog_flag_c", 16'(dp_if.flag_c), 16'h0);
    checkOutput("prog_flag_z", 16'(dp_if.flag_z), 16'h0);
    applyStimulus(W_CO | W_MI);
    applyStimulus(W_RO | W_II | W_CE);
    checkOutput("prog_ir_out", 16'(dp_if.instruction), 16'hE);
    checkOutput("prog_valid_before", 16'(dp_if.out_valid), 16'h0);
    applyStimulus(W_AO | W_OI);
    checkOutput("prog_out_value", 16'(dp_if.out_value), 16'd42);
    checkOutput("prog_valid_pulse", 16'(dp_if.out_valid), 16'h1);
    applyStimulus(W_CO | W_MI);
    checkOutput("prog_valid_drop", 16'(dp_if.out_valid), 16'h0);
    applyStimulus(W_RO | W_II | W_CE);
    checkOutput("prog_ir_hlt", 16'(dp_if.instruction), 16'hF);
    checkOutput("prog_not_halted_yet", 16'(dp_if.halted), 16'h0);
    applyStimulus(W_HLT);
    checkOutput("prog_halted", 16'(dp_if.halted), 16'h1);
    checkOutput("prog_pc", 16'(dp_if.pc), 16'd4);
    checkOutput("prog_no_conflict", 16'(dp_if.bus_conflict), 16'h0);

    // ---- ALU: 5-5 then 3-5 (MAR stays 0 so RO reads ram[0])
    doReset();
    checkOutput("rst_clears_halt", 16'(dp_if.halted), 16'h0);
    progWrite(4'd0, 8'd5);
    applyStimulus(W_RO | W_AI);
    applyStimulus(W_RO | W_BI);
    applyStimulus(W_EO | W_SU | W_AI | W_FI);
    checkOutput("sub_eq_z", 16'(dp_if.flag_z), 16'h1);
    checkOutput("sub_eq_c", 16'(dp_if.flag_c), 16'h1);
    dp_if.ctrl_word = W_AO;
    #1;
    checkOutput("sub_eq_a", 16'(dp_if.bus_value), 16'h00);
    progWrite(4'd0, 8'd3);
    applyStimulus(W_RO | W_AI);
    applyStimulus(W_EO | W_SU | W_AI | W_FI);
    checkOutput("sub_neg_z", 16'(dp_if.flag_z), 16'h0);
    checkOutput("sub_neg_c", 16'(dp_if.flag_c), 16'h0);
    dp_if.ctrl_word = W_AO;
    #1;
    checkOutput("sub_neg_a", 16'(dp_if.bus_value), 16'hFE);
    // plain add with carry out: 0xFE + 5 = 0x103
    applyStimulus(W_EO | W_AI | W_FI);
    checkOutput("add_carry_c", 16'(dp_if.flag_c), 16'h1);
    dp_if.ctrl_word = W_AO;
    #1;
    checkOutput("add_carry_a", 16'(dp_if.bus_value), 16'h03);

    // ---- PC wrap and J beats CE
    doReset();
    progWrite(4'd0, 8'd15);
    applyStimulus(W_J | W_RO);
    checkOutput("pc_jump_15", 16'(dp_if.pc), 16'd15);
    applyStimulus(W_CE);
    checkOutput("pc_wrap", 16'(dp_if.pc), 16'd0);
    progWrite(4'd0, 8'd7);
    applyStimulus(W_J | W_CE | W_RO);
    checkOutput("pc_j_beats_ce", 16'(dp_if.pc), 16'd7);

    // ---- bus conflict: RO wins over AO and the flag sticks
    progWrite(4'd0, 8'h44);
    applyStimulus(W_RO | W_AI);
    progWrite(4'd0, 8'h33);
    checkOutput("conflict_before", 16'(dp_if.bus_conflict), 16'h0);
    dp_if.ctrl_word = W_RO | W_AO;
    #1;
    checkOutput("conflict_bus_prio", 16'(dp_if.bus_value), 16'h33);
    applyStimulus(W_RO | W_AO);
    checkOutput("conflict_set", 16'(dp_if.bus_conflict), 16'h1);
    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    checkOutput("conflict_sticky", 16'(dp_if.bus_conflict), 16'h1);
    doReset();
    checkOutput("conflict_cleared", 16'(dp_if.bus_conflict), 16'h0);

    // ---- halt suppression, loader still writes, reset releases
    progWrite(4'd0, 8'h44);
    applyStimulus(W_RO | W_AI);
    applyStimulus(W_HLT | W_CE);
    checkOutput("hlt_own_ce", 16'(dp_if.pc), 16'd1);
    applyStimulus(W_AO | W_BI | W_CE | W_OI);
    checkOutput("halt_pc_frozen", 16'(dp_if.pc), 16'd1);
    checkOutput("halt_out_frozen", 16'(dp_if.out_value), 16'h00);
    checkOutput("halt_no_valid", 16'(dp_if.out_valid), 16'h0);
    dp_if.ctrl_word = W_EO;
    #1;
    checkOutput("halt_b_frozen", 16'(dp_if.bus_value), 16'h44);
    progWrite(4'd0, 8'h99);
    dp_if.ctrl_word = W_RO;
    #1;
    checkOutput("halt_prog_we", 16'(dp_if.bus_value), 16'h99);
    doReset();
    checkOutput("halt_released", 16'(dp_if.halted), 16'h0);
    applyStimulus(W_RO | W_AI);
    dp_if.ctrl_word = W_AO;
    #1;
    checkOutput("post_rst_ai", 16'(dp_if.bus_value), 16'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
